// File: rtl/risc15_mem_pkg.sv
// Shared types and elaboration helpers for the RISC15 load/store memory responder.
// Holds the FSM state enum, the default word width and the parameter sanity helpers.
package risc15_mem_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The wait counter is loaded with LATENCY-1, so it only needs to hold that value.
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction

  function automatic bit params_ok(input int addr_w, input int depth, input int latency);
    return (addr_w >= 1) && (addr_w <= 30) && (depth >= 1) &&
           (depth <= (1 << addr_w)) && (latency >= 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word store with write enable and no reset.
// Read data updates only on enabled edges; a write returns the written word.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = we ? wdata : mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the RISC15 load/store port: one request at a time,
// fixed wait-state latency, out-of-range addresses reported via rsp_err.
import risc15_mem_pkg::*;

module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  if (!params_ok(ADDR_W, DEPTH, LATENCY)) begin : g_param_check
    $error("mem_responder: illegal ADDR_W/DEPTH/LATENCY combination");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              src_q, src_d;

  logic              accept;
  logic              do_access;
  logic              in_range;
  logic [DATA_W-1:0] ram_rdata;

  assign accept    = req_valid && ready_q;
  assign do_access = (state_q == WAIT) && (cnt_q == '0);
  assign in_range  = ({1'b0, addr_q} < DEPTH_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, wait countdown and response qualifiers; src_q marks data owned by the RAM.
  always_comb begin
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    src_d   = src_q;
    if ((state_q == IDLE) && accept) begin
      cnt_d   = CNT_W'(LATENCY - 1);
      we_d    = req_we;
      addr_d  = req_addr;
      wdata_d = req_wdata;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (do_access) begin
      err_d = !in_range;
      src_d = in_range;
    end
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    req_ready = ready_q;
    rsp_valid = (state_q == RESP);
    rsp_rdata = src_q ? ram_rdata : '0;
    rsp_err   = err_q;
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clk),
    .en    (do_access && in_range),
    .we    (we_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
